md_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same forwarded Operand1/Operand2 the ALU receives.
- Produces a 32-bit result, selected into the EX result path when an M-extension instruction completes.
- Asserts busy so the hazard unit stalls IF/ID/EX until the result is ready.

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_unit.sv | 173 +++++++++++++++++
 tb/tb_md_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit:
// FSM state encoding, funct3 opcodes and the EX result-mux select.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } md_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // EX result mux select for the md_unit output
  localparam logic [2:0] EX_SEL_MD = 3'd5;

endpackage

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit, 34-cycle fixed latency.
// Ports: clk, rst (async high), start, md_op (funct3), operand1/2,
//        flush; outputs busy, done (1-cycle pulse), result (held).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            md_op,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(W - 1);
  localparam logic [W-1:0] SMIN =
    {1'b1, {(W-1){1'b0}}};

  md_state_t state, state_nx;

  logic [2:0]           op_q;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         opb;
  logic                 sign_q;
  logic                 dz_q;
  logic                 ovf_q;
  logic [CNT_WIDTH-1:0] cnt;

  // Incoming op decode
  logic is_div, op1_signed, op2_signed;
  logic s1, s2, sign_in, dz_in, ovf_in;
  logic [W-1:0] mag1, mag2;
  logic accept;

  always_comb begin
    is_div     = md_op[2];
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    unique case (md_op)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      F3_MULHSU: op1_signed = 1'b1;
      default: ;
    endcase
  end

  assign s1   = op1_signed & operand1[W-1];
  assign s2   = op2_signed & operand2[W-1];
  assign mag1 = s1 ? -operand1 : operand1;
  assign mag2 = s2 ? -operand2 : operand2;

  // Remainder follows the dividend; everything else is s1^s2
  assign sign_in = (md_op == F3_REM) ? s1 : (s1 ^ s2);
  assign dz_in   = is_div & (operand2 == '0);
  assign ovf_in  = ((md_op == F3_DIV) | (md_op == F3_REM)) &
                   (operand1 == SMIN) & (operand2 == '1);

  assign accept = start & ~flush &
                  ((state == MD_IDLE) | (state == MD_DONE));

  // Latched op decode
  logic q_div, q_rem, q_low;
  assign q_div = op_q[2];
  assign q_rem = op_q[2] & op_q[1];
  assign q_low = (op_q == F3_MUL);

  // Multiply step: acc = {partial_hi, multiplier bits}
  logic [W:0]     msum;
  logic [2*W-1:0] mul_nx;
  assign msum   = {1'b0, acc[2*W-1:W]} +
                  (acc[0] ? {1'b0, opb} : '0);
  assign mul_nx = {msum, acc[W-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}
  logic [W:0]     shl, diff;
  logic [2*W-1:0] div_nx;
  assign shl  = {acc[2*W-1:W], acc[W-1]};
  assign diff = shl - {1'b0, opb};
  assign div_nx = diff[W] ?
    {shl[W-1:0],  acc[W-2:0], 1'b0} :
    {diff[W-1:0], acc[W-2:0], 1'b1};

  // Sign fix-up and result select
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo_s, rem_s, fix_res;

  assign prod  = sign_q ? -acc : acc;
  assign quo_s = sign_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_s = sign_q ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_comb begin
    fix_res = '0;
    if (!q_div)
      fix_res = q_low ? prod[W-1:0] : prod[2*W-1:W];
    else if (dz_q)
      // rem_s restores the original dividend here
      fix_res = q_rem ? rem_s : '1;
    else if (ovf_q)
      fix_res = q_rem ? '0 : SMIN;
    else
      fix_res = q_rem ? rem_s : quo_s;
  end

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      MD_IDLE: begin
        if (start) state_nx = MD_CALC;
      end
      MD_CALC: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = MD_FIX;
      end
      MD_FIX: begin
        busy     = 1'b1;
        state_nx = MD_DONE;
      end
      MD_DONE: begin
        done     = 1'b1;
        state_nx = start ? MD_CALC : MD_IDLE;
      end
    endcase
    if (flush) state_nx = MD_IDLE;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      acc    <= '0;
      opb    <= '0;
      sign_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q   <= md_op;
      acc    <= {{W{1'b0}}, is_div ? mag1 : mag2};
      opb    <= is_div ? mag2 : mag1;
      sign_q <= sign_in;
      dz_q   <= dz_in;
      ovf_q  <= ovf_in;
      cnt    <= '0;
    end else if (!flush) begin
      if (state == MD_CALC) begin
        acc <= q_div ? div_nx : mul_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == MD_FIX) result <= fix_res;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner
// sequences and random ops against a 64-bit arithmetic model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .operand1(operand1), .operand2(operand2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a start for one edge; returns in the next cycle (cycle 1)
  task automatic issue(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    md_op = op; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles until done; returns at the negedge of done cycle
  task automatic wait_done(input bit noise, output int cyc,
                           output int bad);
    cyc = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (noise && (c == 5 || c == 20)) begin
        start = 1'b1;
        md_op = 3'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
      end
      @(negedge clk);
      if (done) begin
        if (busy) bad++;
        cyc = c;
        break;
      end
      if (!busy) bad++;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp,
      input string nm, input bit noise);
    int cyc, bad;
    issue(op, a, b);
    wait_done(noise, cyc, bad);
    chk({nm, "_lat"}, cyc, 34);
    chk({nm, "_busy"}, bad, 0);
    chk({nm, "_res"}, result, exp);
    @(posedge clk); #1;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, bad, nd;
    logic [31:0] held, a, b, e;
    logic [2:0]  op;

    tbl[0]  = '{3'd0, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul"};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh"};
    tbl[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"};
    tbl[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu"};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, "div"};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, "rem"};
    tbl[6]  = '{3'd5, 32'h5,         32'h0,         32'hFFFF_FFFF, "divu0"};
    tbl[7]  = '{3'd7, 32'h5,         32'h0,         32'h5,         "remu0"};
    tbl[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf"};
    tbl[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "removf"};
    tbl[10] = '{3'd4, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, "div0"};
    tbl[11] = '{3'd6, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, "rem0"};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm, 1'b0);

    // Start pulses while busy must be ignored
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "noise_divu", 1'b1);

    // Back-to-back: new start during the DONE cycle
    issue(3'd0, 32'd6, 32'd7);
    wait_done(1'b0, cyc, bad);
    chk("b2b1_lat", cyc, 34);
    chk("b2b1_res", result, 32'd42);
    md_op = 3'd3; operand1 = 32'h1_0000; operand2 = 32'h3_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc, bad);
    chk("b2b2_lat", cyc, 34);
    chk("b2b2_busy", bad, 0);
    chk("b2b2_res", result, 32'h3);
    @(posedge clk); #1;

    // Flush at cycle 10 of a DIV
    held = result;
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 0);
    count_done(40, nd);
    chk("flush_nodone", nd, 0);
    chk("flush_result", result, held);
    run_op(3'd4, 32'd1000, 32'd3, 32'd333, "post_flush", 1'b0);

    // Flush and start on the same idle edge: flush wins
    md_op = 3'd0; operand1 = 32'd9; operand2 = 32'd9;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fs_busy", {31'b0, busy}, 0);
    count_done(40, nd);
    chk("fs_nodone", nd, 0);
    chk("fs_result", result, 32'd333);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom);
      a  = pick();
      b  = pick();
      e  = ref_md(op, a, b);
      run_op(op, a, b, e, $sformatf("rnd%0d_op%0d", i, op), 1'b0);
    end

    // Async reset mid-CALC
    run_op(3'd0, 32'd5, 32'd5, 32'd25, "pre_rst", 1'b0);
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    chk("mrst_result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_done(40, nd);
    chk("mrst_nodone", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
